// File: rtl/alarm_snooze_ctrl_if.sv
// Signal bundle between the alarm time comparator/buttons and the wake-up controller.
// The master drives the alarm and button inputs; the slave (controller) drives the buzzer/display status.
interface alarm_snooze_ctrl_if #(
  parameter int SNZ_W = 2
);
  logic             alarme;
  logic             dia_util;
  logic             soneca;
  logic             confirmar;
  logic             novo_dia;
  logic             tocando;
  logic             desligar;
  logic             levantado;
  logic [SNZ_W-1:0] snooze_count;
  logic [1:0]       estado;

  modport master (
    output alarme, dia_util, soneca, confirmar, novo_dia,
    input  tocando, desligar, levantado, snooze_count, estado
  );

  modport slave (
    input  alarme, dia_util, soneca, confirmar, novo_dia,
    output tocando, desligar, levantado, snooze_count, estado
  );
endinterface

// File: rtl/alarm_snooze_ctrl.sv
// Wake-up controller: sleeping -> ringing <-> bounded snooze loop -> up, re-armed by the midnight pulse.
// All outputs come straight from flops that are loaded from the next-state logic.
module alarm_snooze_ctrl #(
  parameter int SNOOZE_CYCLES = 8,
  parameter int RING_CYCLES   = 16,
  parameter int MAX_SNOOZE    = 3,
  parameter int CNT_W         = 8,
  parameter int SNZ_W         = 2
) (
  input  logic                clock,
  input  logic                reset,
  alarm_snooze_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    DORMINDO  = 2'd0,
    TOCANDO   = 2'd1,
    SONECA    = 2'd2,
    LEVANTADO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_CYCLES - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_CYCLES - 1);
  localparam logic [SNZ_W-1:0] SNZ_LIMIT   = SNZ_W'(MAX_SNOOZE);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [SNZ_W-1:0] r_snz;
  logic [SNZ_W-1:0] w_next_snz;
  logic             r_tocando;
  logic             r_desligar;
  logic             r_levantado;
  logic             w_can_snooze;
  logic             w_snooze_req;

  // Counter saturates instead of wrapping, so a capped ringing phase can last forever.
  assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_can_snooze = (r_snz < SNZ_LIMIT);
  assign w_snooze_req = bus.soneca || (r_cnt == RING_LAST);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = w_cnt_inc;
    w_next_snz   = r_snz;
    case (r_state)
      DORMINDO: begin
        w_next_cnt = '0;
        if (bus.alarme && bus.dia_util) begin
          w_next_state = TOCANDO;
          w_next_snz   = '0;
        end
      end
      TOCANDO: begin
        if (bus.confirmar) begin
          w_next_state = LEVANTADO;
          w_next_cnt   = '0;
        end else if (w_snooze_req && w_can_snooze) begin
          w_next_state = SONECA;
          w_next_cnt   = '0;
          w_next_snz   = r_snz + SNZ_W'(1);
        end
      end
      SONECA: begin
        if (bus.confirmar) begin
          w_next_state = LEVANTADO;
          w_next_cnt   = '0;
        end else if (r_cnt == SNOOZE_LAST) begin
          w_next_state = TOCANDO;
          w_next_cnt   = '0;
        end
      end
      LEVANTADO: begin
        w_next_cnt = '0;
      end
      default: begin
        w_next_state = DORMINDO;
        w_next_cnt   = '0;
      end
    endcase
    // Midnight re-arm overrides every state-local decision.
    if (bus.novo_dia) begin
      w_next_state = DORMINDO;
      w_next_cnt   = '0;
      w_next_snz   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= DORMINDO;
      r_cnt       <= '0;
      r_snz       <= '0;
      r_tocando   <= 1'b0;
      r_desligar  <= 1'b0;
      r_levantado <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_snz       <= w_next_snz;
      r_tocando   <= (w_next_state == TOCANDO);
      r_desligar  <= (w_next_state == LEVANTADO) && (r_state != LEVANTADO);
      r_levantado <= (w_next_state == LEVANTADO);
    end
  end

  assign bus.tocando      = r_tocando;
  assign bus.desligar     = r_desligar;
  assign bus.levantado    = r_levantado;
  assign bus.snooze_count = r_snz;
  assign bus.estado       = r_state;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Bench for alarm_snooze_ctrl: directed scenarios plus a randomized run against a countdown-based model.
module tb_alarm_snooze_ctrl;

  localparam int SNOOZE_CYCLES = 8;
  localparam int RING_CYCLES   = 16;
  localparam int MAX_SNOOZE    = 3;
  localparam int CNT_W         = 8;
  localparam int SNZ_W         = 2;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  // Reference model: phase code plus "cycles left" countdown.
  int m_st;
  int m_left;
  int m_snz;
  bit m_des;

  alarm_snooze_ctrl_if #(.SNZ_W(SNZ_W)) bus ();

  alarm_snooze_ctrl #(
    .SNOOZE_CYCLES(SNOOZE_CYCLES),
    .RING_CYCLES  (RING_CYCLES),
    .MAX_SNOOZE   (MAX_SNOOZE),
    .CNT_W        (CNT_W),
    .SNZ_W        (SNZ_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model ----------------
  function automatic void model_reset();
    m_st   = 0;
    m_left = 0;
    m_snz  = 0;
    m_des  = 1'b0;
  endfunction

  function automatic void model_update(input bit a, input bit d, input bit s,
                                       input bit c, input bit n);
    int prev;
    prev = m_st;
    if (n) begin
      m_st  = 0;
      m_snz = 0;
    end else begin
      case (m_st)
        0: if (a && d) begin
          m_st   = 1;
          m_left = RING_CYCLES;
          m_snz  = 0;
        end
        1: if (c) begin
          m_st = 3;
        end else if ((s || m_left == 1) && m_snz < MAX_SNOOZE) begin
          m_st   = 2;
          m_left = SNOOZE_CYCLES;
          m_snz  = m_snz + 1;
        end else if (m_left > 1) begin
          m_left = m_left - 1;
        end
        2: if (c) begin
          m_st = 3;
        end else if (m_left == 1) begin
          m_st   = 1;
          m_left = RING_CYCLES;
        end else begin
          m_left = m_left - 1;
        end
        default: ;
      endcase
    end
    m_des = (m_st == 3) && (prev != 3);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit a, input bit d, input bit s, input bit c, input bit n);
    bus.alarme    = a;
    bus.dia_util  = d;
    bus.soneca    = s;
    bus.confirmar = c;
    bus.novo_dia  = n;
    @(posedge clock);
    model_update(a, d, s, c, n);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.alarme = 0; bus.dia_util = 0; bus.soneca = 0; bus.confirmar = 0; bus.novo_dia = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (bus.estado !== 2'd0) begin
      miscompares++; $display("FAIL reset_estado got=%0d want=0", bus.estado);
    end
    vectors++;
    if ({bus.tocando, bus.desligar, bus.levantado} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=000", {bus.tocando, bus.desligar, bus.levantado});
    end
    vectors++;
    if (bus.snooze_count !== '0) begin
      miscompares++; $display("FAIL reset_snooze got=%0d want=0", bus.snooze_count);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_weekday();
    step(1, 1, 0, 0, 0);
    vectors++;
    if (bus.tocando !== 1'b1 || bus.estado !== 2'd1) begin
      miscompares++;
      $display("FAIL weekday_ring tocando=%b estado=%0d want 1/1", bus.tocando, bus.estado);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (bus.desligar !== 1'b1 || bus.levantado !== 1'b1 || bus.estado !== 2'd3) begin
      miscompares++;
      $display("FAIL weekday_confirm desligar=%b levantado=%b estado=%0d want 1/1/3",
               bus.desligar, bus.levantado, bus.estado);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (bus.desligar !== 1'b0 || bus.levantado !== 1'b1 || bus.tocando !== 1'b0) begin
      miscompares++;
      $display("FAIL weekday_pulse desligar=%b levantado=%b tocando=%b want 0/1/0",
               bus.desligar, bus.levantado, bus.tocando);
    end
    step(1, 1, 0, 0, 1);
    vectors++;
    if (bus.estado !== 2'd0 || bus.levantado !== 1'b0 || bus.snooze_count !== '0) begin
      miscompares++;
      $display("FAIL novo_dia estado=%0d levantado=%b snz=%0d want 0/0/0",
               bus.estado, bus.levantado, bus.snooze_count);
    end
  endtask

  task automatic test_weekend();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, i[0], i[1], 0);
      if (bus.estado !== 2'd0 || bus.tocando !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL weekend bad_cycles=%0d want=0 last estado=%0d", bad, bus.estado);
    end
  endtask

  task automatic test_snooze();
    int quiet;
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    quiet = 0;
    for (int i = 0; i < SNOOZE_CYCLES; i++) begin
      if (bus.tocando === 1'b0 && bus.estado === 2'd2) quiet++;
      if (i != SNOOZE_CYCLES - 1) step(0, 0, 1, 0, 0);
    end
    vectors++;
    if (quiet != SNOOZE_CYCLES) begin
      miscompares++; $display("FAIL snooze_quiet got=%0d want=%0d", quiet, SNOOZE_CYCLES);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (bus.tocando !== 1'b1 || bus.snooze_count !== SNZ_W'(1)) begin
      miscompares++;
      $display("FAIL snooze_resume tocando=%b snz=%0d want 1/1", bus.tocando, bus.snooze_count);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_limit();
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < MAX_SNOOZE; k++) begin
      step(0, 0, 1, 0, 0);
      idle(SNOOZE_CYCLES);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (bus.tocando !== 1'b1 || bus.estado !== 2'd1 || bus.snooze_count !== SNZ_W'(MAX_SNOOZE)) begin
      miscompares++;
      $display("FAIL limit_ignore tocando=%b estado=%0d snz=%0d want 1/1/%0d",
               bus.tocando, bus.estado, bus.snooze_count, MAX_SNOOZE);
    end
    idle(RING_CYCLES + 4);
    vectors++;
    if (bus.tocando !== 1'b1 || bus.estado !== 2'd1) begin
      miscompares++;
      $display("FAIL limit_timeout tocando=%b estado=%0d want 1/1", bus.tocando, bus.estado);
    end
    step(0, 0, 1, 1, 0);
    vectors++;
    if (bus.estado !== 2'd3 || bus.desligar !== 1'b1) begin
      miscompares++;
      $display("FAIL limit_confirm estado=%0d desligar=%b want 3/1", bus.estado, bus.desligar);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_timeout();
    int ringing;
    step(1, 1, 0, 0, 0);
    ringing = 0;
    for (int i = 0; i < RING_CYCLES - 1; i++) begin
      step(0, 0, 0, 0, 0);
      if (bus.tocando === 1'b1) ringing++;
    end
    vectors++;
    if (ringing != RING_CYCLES - 1) begin
      miscompares++; $display("FAIL timeout_ringing got=%0d want=%0d", ringing, RING_CYCLES - 1);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (bus.estado !== 2'd2 || bus.tocando !== 1'b0 || bus.snooze_count !== SNZ_W'(1)) begin
      miscompares++;
      $display("FAIL timeout_auto estado=%0d tocando=%b snz=%0d want 2/0/1",
               bus.estado, bus.tocando, bus.snooze_count);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (bus.desligar !== 1'b1 || bus.estado !== 2'd3) begin
      miscompares++;
      $display("FAIL snooze_confirm desligar=%b estado=%0d want 1/3", bus.desligar, bus.estado);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(2);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (bus.estado !== 2'd0 || bus.tocando !== 1'b0 || bus.snooze_count !== '0) begin
      miscompares++;
      $display("FAIL reset_async estado=%0d tocando=%b snz=%0d want 0/0/0",
               bus.estado, bus.tocando, bus.snooze_count);
    end
    #3;
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_random();
    bit a, d, s, c, n;
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 29) == 0);
      n = ($urandom_range(0, 69) == 0);
      step(a, d, s, c, n);
      vectors++;
      if (bus.estado !== 2'(m_st)) begin
        miscompares++; $display("FAIL rnd_estado cyc=%0d got=%0d want=%0d", i, bus.estado, m_st);
      end
      vectors++;
      if (bus.tocando !== (m_st == 1)) begin
        miscompares++; $display("FAIL rnd_tocando cyc=%0d got=%b want=%b", i, bus.tocando, m_st == 1);
      end
      vectors++;
      if (bus.levantado !== (m_st == 3)) begin
        miscompares++; $display("FAIL rnd_levantado cyc=%0d got=%b want=%b", i, bus.levantado, m_st == 3);
      end
      vectors++;
      if (bus.desligar !== m_des) begin
        miscompares++; $display("FAIL rnd_desligar cyc=%0d got=%b want=%b", i, bus.desligar, m_des);
      end
      vectors++;
      if (bus.snooze_count !== SNZ_W'(m_snz)) begin
        miscompares++; $display("FAIL rnd_snooze cyc=%0d got=%0d want=%0d", i, bus.snooze_count, m_snz);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_weekday();
    test_weekend();
    test_snooze();
    test_limit();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
